// File: rtl/lab6_pkg.sv
// Shared definitions for the Lab 6 master/slave link: data width,
// the "no selection" code and the master handshake state encoding.
package lab6_pkg;

  localparam int DATA_W = 4;
  localparam logic [DATA_W-1:0] NO_DATA = 4'b1000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STABLE = 3'd1,
    REQ    = 3'd2,
    REL    = 3'd3,
    HOLD   = 3'd4
  } lab6_state_e;

  // Codes 0-7 are selections; anything with the top bit set means "none".
  function automatic logic is_valid(input logic [DATA_W-1:0] code);
    return (code[DATA_W-1] == 1'b0);
  endfunction

endpackage

// File: rtl/lab6_sync2.sv
// Generic two-flop synchronizer for signals crossing into the clk domain.
// Both stages clear to zero on reset.
module lab6_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/lab6_link_master_ctrl.sv
// Master-side handshake sequencer: debounces the encoder code, runs one
// four-phase req/ack transfer per selection, flags timeouts, counts sends.
module lab6_link_master_ctrl
  import lab6_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ack,
  output logic              request,
  output logic [DATA_W-1:0] data_to_slave,
  output logic              busy,
  output logic              timeout_err,
  output logic [7:0]        sent_count
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES);
  localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT_CYCLES);

  lab6_state_e        state_r;
  logic [DATA_W-1:0]  cand_r;
  logic [STAB_W-1:0]  stab_cnt_r;
  logic [TO_W-1:0]    to_cnt_r;
  logic               request_r;
  logic [DATA_W-1:0]  data_r;
  logic               busy_r;
  logic               timeout_err_r;
  logic [7:0]         sent_count_r;

  logic               ack_s;
  logic [TO_W-1:0]    to_inc_s;
  logic               to_expire_s;
  logic [STAB_W-1:0]  stab_nxt_s;
  logic               stab_done_s;

  lab6_sync2 #(.WIDTH(1)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack),
    .q     (ack_s)
  );

  // Saturating timeout increment and debounce completion decode
  always_comb begin
    to_inc_s = to_cnt_r;
    if (to_cnt_r == TO_MAX) begin
      to_inc_s = to_cnt_r;
    end else begin
      to_inc_s = to_cnt_r + TO_ONE;
    end
    to_expire_s = (to_inc_s == TO_MAX);
    stab_nxt_s  = stab_cnt_r + STAB_ONE;
    stab_done_s = (stab_nxt_s == STAB_LAST);
  end

  // Handshake FSM with debounce, timeout and transfer counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cand_r        <= NO_DATA;
      stab_cnt_r    <= '0;
      to_cnt_r      <= '0;
      request_r     <= 1'b0;
      data_r        <= NO_DATA;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      sent_count_r  <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (is_valid(data_in)) begin
            cand_r     <= data_in;
            stab_cnt_r <= STAB_ONE;
            busy_r     <= 1'b1;
            if (STABLE_CYCLES == 1) begin
              data_r    <= data_in;
              request_r <= 1'b1;
              to_cnt_r  <= '0;
              state_r   <= REQ;
            end else begin
              state_r <= STABLE;
            end
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        STABLE: begin
          if (data_in != cand_r) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (stab_done_s) begin
            stab_cnt_r <= stab_nxt_s;
            data_r     <= cand_r;
            request_r  <= 1'b1;
            to_cnt_r   <= '0;
            state_r    <= REQ;
          end else begin
            stab_cnt_r <= stab_nxt_s;
          end
        end
        REQ: begin
          if (ack_s) begin
            request_r <= 1'b0;
            to_cnt_r  <= '0;
            state_r   <= REL;
          end else if (to_expire_s) begin
            request_r     <= 1'b0;
            timeout_err_r <= 1'b1;
            state_r       <= HOLD;
          end else begin
            to_cnt_r <= to_inc_s;
          end
        end
        REL: begin
          if (!ack_s) begin
            sent_count_r  <= sent_count_r + 8'd1;
            timeout_err_r <= 1'b0;
            state_r       <= HOLD;
          end else if (to_expire_s) begin
            timeout_err_r <= 1'b1;
            state_r       <= HOLD;
          end else begin
            to_cnt_r <= to_inc_s;
          end
        end
        HOLD: begin
          // A held switch must never retransmit; only a new code releases HOLD.
          if (data_in != data_r) begin
            data_r  <= NO_DATA;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          request_r <= 1'b0;
          data_r    <= NO_DATA;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign request       = request_r;
  assign data_to_slave = data_r;
  assign busy          = busy_r;
  assign timeout_err   = timeout_err_r;
  assign sent_count    = sent_count_r;

endmodule

// File: tb/tb_lab6_link_master_ctrl.sv
// Directed bench for lab6_link_master_ctrl with a behavioural slave that
// answers request with ack after a programmable delay.
module tb_lab6_link_master_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] data_in;
  logic       ack;
  logic       request;
  logic [3:0] data_to_slave;
  logic       busy;
  logic       timeout_err;
  logic [7:0] sent_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int req_rises    = 0;
  logic req_q      = 1'b0;
  logic slave_en   = 1'b0;
  int   slave_dly  = 3;

  lab6_link_master_ctrl #(
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .ack           (ack),
    .request       (request),
    .data_to_slave (data_to_slave),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .sent_count    (sent_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: raise ack slave_dly cycles after request, drop it once request falls.
  initial begin
    ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!slave_en) begin
        ack = 1'b0;
      end else if (!ack && request) begin
        repeat (slave_dly) @(posedge clk);
        #2;
        ack = 1'b1;
      end else if (ack && !request) begin
        ack = 1'b0;
      end
    end
  end

  // Counts request rising edges to catch missing or duplicated pulses.
  always @(posedge clk) begin
    #1;
    if (request && !req_q) req_rises = req_rises + 1;
    req_q = request;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_sent_change(input logic [7:0] prev, input int max_cyc);
    int n;
    n = 0;
    while (n < max_cyc) begin
      @(negedge clk);
      if (sent_count !== prev) n = max_cyc;
      else n = n + 1;
    end
  endtask

  task automatic wait_req(input logic lvl, input int max_cyc);
    int n;
    n = 0;
    while (n < max_cyc) begin
      @(negedge clk);
      if (request === lvl) n = max_cyc;
      else n = n + 1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; data_in = 4'd8; slave_en = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (request !== 1'b0) begin tests_failed++; $display("FAIL reset_request got=%b exp=0", request); end
    tests_run++; if (data_to_slave !== 4'b1000) begin tests_failed++; $display("FAIL reset_data got=%h exp=8", data_to_slave); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout got=%b exp=0", timeout_err); end
    tests_run++; if (sent_count !== 8'd0) begin tests_failed++; $display("FAIL reset_count got=%0d exp=0", sent_count); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_req;
    slave_en = 1'b0;
    data_in = 4'd4;
    repeat (4) @(negedge clk);
    tests_run++; if (request !== 1'b1) begin tests_failed++; $display("FAIL midreq_request_up got=%b exp=1", request); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (request !== 1'b0) begin tests_failed++; $display("FAIL midreq_async_drop got=%b exp=0", request); end
    tests_run++; if (data_to_slave !== 4'b1000) begin tests_failed++; $display("FAIL midreq_data got=%h exp=8", data_to_slave); end
    tests_run++; if (sent_count !== 8'd0) begin tests_failed++; $display("FAIL midreq_count got=%0d exp=0", sent_count); end
    data_in = 4'd8;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midreq_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic;
    logic [7:0] s0;
    int r0;
    s0 = sent_count; r0 = req_rises;
    slave_dly = 3; slave_en = 1'b1;
    @(negedge clk); data_in = 4'd5;
    repeat (3) @(negedge clk);
    tests_run++; if (request !== 1'b0) begin tests_failed++; $display("FAIL basic_req_early got=%b exp=0", request); end
    @(negedge clk);
    tests_run++; if (request !== 1'b1) begin tests_failed++; $display("FAIL basic_req_rise got=%b exp=1", request); end
    tests_run++; if (data_to_slave !== 4'd5) begin tests_failed++; $display("FAIL basic_data got=%h exp=5", data_to_slave); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy got=%b exp=1", busy); end
    for (int i = 0; i < 10 && ack !== 1'b1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    tests_run++; if (request !== 1'b1) begin tests_failed++; $display("FAIL basic_req_hold got=%b exp=1", request); end
    @(negedge clk);
    tests_run++; if (request !== 1'b0) begin tests_failed++; $display("FAIL basic_req_fall got=%b exp=0", request); end
    wait_sent_change(s0, 20);
    tests_run++; if (sent_count !== s0 + 8'd1) begin tests_failed++; $display("FAIL basic_count got=%0d exp=%0d", sent_count, s0 + 8'd1); end
    tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL basic_timeout got=%b exp=0", timeout_err); end
    repeat (6) @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL basic_hold_busy got=%b exp=1", busy); end
    tests_run++; if (data_to_slave !== 4'd5) begin tests_failed++; $display("FAIL basic_hold_data got=%h exp=5", data_to_slave); end
    tests_run++; if (req_rises !== r0 + 1) begin tests_failed++; $display("FAIL basic_pulses got=%0d exp=%0d", req_rises, r0 + 1); end
    data_in = 4'd8;
    @(negedge clk);
    tests_run++; if (data_to_slave !== 4'b1000) begin tests_failed++; $display("FAIL basic_release_data got=%h exp=8", data_to_slave); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_release_busy got=%b exp=0", busy); end
    @(negedge clk);
  endtask

  task automatic test_glitch;
    logic [7:0] s0;
    int r0;
    s0 = sent_count; r0 = req_rises;
    @(negedge clk); data_in = 4'd3;
    @(negedge clk); data_in = 4'd8;
    @(negedge clk); data_in = 4'd2;
    repeat (3) @(negedge clk);
    tests_run++; if (request !== 1'b0) begin tests_failed++; $display("FAIL glitch_no_early_req got=%b exp=0", request); end
    tests_run++; if (data_to_slave !== 4'b1000) begin tests_failed++; $display("FAIL glitch_no_load got=%h exp=8", data_to_slave); end
    @(negedge clk);
    tests_run++; if (request !== 1'b1) begin tests_failed++; $display("FAIL glitch_req_rise got=%b exp=1", request); end
    tests_run++; if (data_to_slave !== 4'd2) begin tests_failed++; $display("FAIL glitch_data got=%h exp=2", data_to_slave); end
    wait_sent_change(s0, 30);
    tests_run++; if (sent_count !== s0 + 8'd1) begin tests_failed++; $display("FAIL glitch_count got=%0d exp=%0d", sent_count, s0 + 8'd1); end
    tests_run++; if (req_rises !== r0 + 1) begin tests_failed++; $display("FAIL glitch_pulses got=%0d exp=%0d", req_rises, r0 + 1); end
    data_in = 4'd8;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout;
    logic [7:0] s0;
    s0 = sent_count;
    slave_en = 1'b0;
    @(negedge clk); data_in = 4'd7;
    repeat (4) @(negedge clk);
    tests_run++; if (request !== 1'b1) begin tests_failed++; $display("FAIL tmo_req_rise got=%b exp=1", request); end
    repeat (15) @(negedge clk);
    tests_run++; if (request !== 1'b1) begin tests_failed++; $display("FAIL tmo_req_still_up got=%b exp=1", request); end
    @(negedge clk);
    tests_run++; if (request !== 1'b0) begin tests_failed++; $display("FAIL tmo_req_fall got=%b exp=0", request); end
    tests_run++; if (timeout_err !== 1'b1) begin tests_failed++; $display("FAIL tmo_flag got=%b exp=1", timeout_err); end
    tests_run++; if (sent_count !== s0) begin tests_failed++; $display("FAIL tmo_count got=%0d exp=%0d", sent_count, s0); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL tmo_hold_busy got=%b exp=1", busy); end
    data_in = 4'd8;
    repeat (2) @(negedge clk);
    tests_run++; if (timeout_err !== 1'b1) begin tests_failed++; $display("FAIL tmo_sticky got=%b exp=1", timeout_err); end
    slave_en = 1'b1; slave_dly = 2;
    data_in = 4'd3;
    wait_sent_change(s0, 40);
    tests_run++; if (sent_count !== s0 + 8'd1) begin tests_failed++; $display("FAIL tmo_recover_count got=%0d exp=%0d", sent_count, s0 + 8'd1); end
    tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL tmo_recover_clear got=%b exp=0", timeout_err); end
    data_in = 4'd8;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_change_in_rel;
    logic [7:0] s0;
    int r0;
    s0 = sent_count; r0 = req_rises;
    slave_en = 1'b1; slave_dly = 3;
    @(negedge clk); data_in = 4'd6;
    wait_req(1'b1, 10);
    wait_req(1'b0, 20);
    data_in = 4'd1;
    wait_sent_change(s0, 20);
    tests_run++; if (sent_count !== s0 + 8'd1) begin tests_failed++; $display("FAIL rel_count got=%0d exp=%0d", sent_count, s0 + 8'd1); end
    tests_run++; if (data_to_slave !== 4'd6) begin tests_failed++; $display("FAIL rel_latched_data got=%h exp=6", data_to_slave); end
    wait_req(1'b1, 20);
    tests_run++; if (data_to_slave !== 4'd1) begin tests_failed++; $display("FAIL rel_next_data got=%h exp=1", data_to_slave); end
    wait_sent_change(s0 + 8'd1, 30);
    tests_run++; if (sent_count !== s0 + 8'd2) begin tests_failed++; $display("FAIL rel_next_count got=%0d exp=%0d", sent_count, s0 + 8'd2); end
    tests_run++; if (req_rises !== r0 + 2) begin tests_failed++; $display("FAIL rel_pulses got=%0d exp=%0d", req_rises, r0 + 2); end
    data_in = 4'd8;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_cnt;
    logic [3:0] val;
    int r0;
    r0 = req_rises;
    exp_cnt = sent_count;
    tests_run++; if (sent_count !== 8'd5) begin tests_failed++; $display("FAIL b2b_start_count got=%0d exp=5", sent_count); end
    slave_en = 1'b1; slave_dly = 1;
    for (int i = 0; i < 256; i++) begin
      val = (i % 2 == 0) ? 4'd0 : 4'd7;
      @(negedge clk); data_in = val;
      wait_sent_change(exp_cnt, 40);
      exp_cnt = exp_cnt + 8'd1;
      tests_run++; if (sent_count !== exp_cnt || data_to_slave !== val) begin
        tests_failed++;
        $display("FAIL b2b_xfer_%0d got=%0d/%h exp=%0d/%h", i, sent_count, data_to_slave, exp_cnt, val);
      end
    end
    tests_run++; if (sent_count !== 8'd5) begin tests_failed++; $display("FAIL b2b_wrap got=%0d exp=5", sent_count); end
    tests_run++; if (req_rises !== r0 + 256) begin tests_failed++; $display("FAIL b2b_pulses got=%0d exp=%0d", req_rises, r0 + 256); end
    data_in = 4'd8;
    repeat (3) @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_final_idle got=%b exp=0", busy); end
  endtask

  initial begin
    rst_n = 1'b0;
    data_in = 4'd8;
    test_reset;
    test_reset_mid_req;
    test_basic;
    test_glitch;
    test_timeout;
    test_change_in_rel;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lab6_link_master_ctrl.md
# lab6_link_master_ctrl

Handshake sequencer between the switch encoder and the slave board in the Lab 6 master/slave link. Takes the encoder's 4-bit code (0–7 valid, 4'b1000 = no/invalid selection), debounces it and drives a four-phase req/ack transfer to the slave. It also enforces one transfer per selection and reports timeouts and a transfer count.

## Interface
- STABLE_CYCLES, 4: consecutive identical valid samples required before a transfer starts (≥1)
- TIMEOUT_CYCLES, 1000: max cycles spent waiting for each ack phase
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- data_in  input  4  encoder code; values 0–7 valid, 4'b1000 = none; any value ≥8 treated as none
- ack  input  1  slave acknowledge, asynchronous to clk
- request  output  1  registered request to slave
- data_to_slave  output  4  registered data to slave
- busy  output  1  high in any state other than IDLE
- timeout_err  output  1  sticky timeout flag
- sent_count  output  8  completed transfers, wraps 255→0

## Operation
- ack passes through a 2-flop synchronizer. All logic uses the synchronized ack_s.
- States: IDLE, STABLE, REQ, REL, HOLD.
- IDLE: if data_in valid, capture it as cand, set stab_cnt=1, go STABLE. If STABLE_CYCLES==1, go directly to REQ with the same loads as STABLE completion.
- STABLE: if data_in ≠ cand, go IDLE. Otherwise stab_cnt++. When stab_cnt reaches STABLE_CYCLES, load data_to_slave=cand, request=1, clear the timeout counter, go REQ.
- REQ: on ack_s==1, request=0, clear the timeout counter, go REL.
- REL: on ack_s==0, sent_count++, timeout_err=0, go HOLD. data_to_slave is unchanged.
- Timeout in REQ or REL: when the counter reaches TIMEOUT_CYCLES with no qualifying ack_s, request=0, timeout_err=1, go HOLD. sent_count is not incremented.
- HOLD: stay while data_in == data_to_slave. When it differs, go IDLE and set data_to_slave=4'b1000. A held switch therefore never retransmits.
- data_in changes during REQ/REL are ignored. The transfer completes or times out with the latched value.
- The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates. stab_cnt is $clog2(STABLE_CYCLES+1) bits.
- Reset values (async assert, clean deassert on clk): request=0, data_to_slave=4'b1000, busy=0, timeout_err=0, sent_count=0, state=IDLE, synchronizer flops=0.
- Reset asserted mid-transfer: request drops immediately. No count is recorded and the link restarts from IDLE.

## Timing
- All outputs are registered. There are no combinational input→output paths.
- Edge E0 first samples valid data_in. request and data_to_slave update at edge E0+STABLE_CYCLES-1 when data_in is held constant, so request is visible after that edge.
- ack→ack_s latency is 2 edges. request falls 1 edge after ack_s rises, i.e. 3 edges after ack rises.
- sent_count increments 1 edge after ack_s falls.
- data_to_slave is stable from the edge that raises request until the state leaves HOLD.
- ack already high when entering REQ: completes REQ on the first cycle (slave protocol error, not detected).

## Structure
- Shared package lab6_pkg: state enum (IDLE, STABLE, REQ, REL, HOLD), constant NO_DATA = 4'b1000, DATA_W = 4.
- Sub-module lab6_sync2: generic 2-flop synchronizer, async active-low reset to 0. Reusable by the slave side.
- Everything else lives in one always_ff FSM plus counters, about 150–250 lines.

## Test plan
- Reset mid-REQ (rst_n low while request=1) → request=0 asynchronously, data_to_slave=4'b1000, sent_count unchanged.
- data_in=5 held 10 cycles, slave model acks 3 cycles after request → request rises after 4th sample, data_to_slave=5, one transfer, sent_count=1, then HOLD until data_in=8 → IDLE, data_to_slave=8.
- data_in glitches 3→8 on the 2nd cycle, then 2 held → no transfer of 3; one transfer of 2.
- Slave never acks, TIMEOUT_CYCLES=16 → request falls after 16 cycles in REQ, timeout_err=1, sent_count=0. Next good transfer clears timeout_err and gives sent_count=1.
- data_in changes 6→1 while in REL → transferred value remains 6, then HOLD exits to IDLE and 1 is transferred next.
- 256 back-to-back transfers alternating 0/7 → sent_count wraps to 0, no missed or duplicated request pulses.
